// File: rtl/pulse_word_scheduler.sv
// Pulse word scheduler: converts (delay, width) pulse commands in fine ticks into
// the 8-bit word fed to an 8:1 serializer each clk1x cycle (bit 0 leaves first).
module pulse_word_scheduler #(
  parameter int DW      = 16,
  parameter int MIN_GAP = 8
) (
  input  logic          clk1x,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [DW-1:0] cmd_delay,
  input  logic [DW-1:0] cmd_width,
  input  logic          abort,
  output logic [7:0]    word,
  output logic          busy,
  output logic          pulse_done,
  output logic          gap_err
);

  localparam int CW = DW + 4;

  typedef enum logic [1:0] {IDLE, DELAY, HIGH} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   off_q, off_d;
  logic [CW-1:0]   rem_q, rem_d;
  logic            holdValid_q, holdValid_d;
  logic [DW-1:0]   holdDelay_q, holdDelay_d;
  logic [DW-1:0]   holdWidth_q, holdWidth_d;
  logic [7:0]      word_q, word_d;
  logic            done_q, done_d;
  logic            gap_q, gap_d;

  logic            curActive;
  logic [CW-1:0]   curOff, curRem, curEnd;
  logic            finalWord, holdTaken, accept, acceptLive;
  logic            chainFromHold, bypass;
  logic [DW-1:0]   chainDelay, chainWidth;
  logic [CW-1:0]   chainDp;

  // The word being produced this cycle is described by (offset to first high
  // tick, remaining high ticks), both relative to tick 0 of that word. From
  // IDLE the holding register feeds it directly so the load edge already
  // carries the first ticks of the pulse.
  always_comb begin
    curActive = 1'b1;
    curOff    = off_q;
    curRem    = rem_q;
    if (state_q == IDLE) begin
      curActive = holdValid_q;
      curOff    = CW'(holdDelay_q);
      curRem    = CW'(holdWidth_q);
    end
    curEnd        = curOff + curRem;
    finalWord     = curActive && (curOff < CW'(8)) && (curEnd <= CW'(8));
    holdTaken     = holdValid_q && ((state_q == IDLE) || finalWord);
    cmd_ready     = !abort && (!holdValid_q || holdTaken);
    accept        = cmd_valid && cmd_ready;
    acceptLive    = accept && (cmd_width != '0);
    chainFromHold = (state_q != IDLE) && holdValid_q;
    // A command arriving on the very edge its predecessor ends can still be
    // chained, even though the holding register is busy with that predecessor.
    bypass        = finalWord && !chainFromHold && acceptLive;
    chainDelay    = chainFromHold ? holdDelay_q : cmd_delay;
    chainWidth    = chainFromHold ? holdWidth_q : cmd_width;
    chainDp       = (CW'(chainDelay) < CW'(MIN_GAP)) ? CW'(MIN_GAP) : CW'(chainDelay);
  end

  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    rem_d       = rem_q;
    word_d      = '0;
    done_d      = 1'b0;
    gap_d       = gap_q;
    holdValid_d = holdValid_q && !holdTaken;
    holdDelay_d = holdDelay_q;
    holdWidth_d = holdWidth_q;

    for (int i = 0; i < 8; i++) begin
      word_d[i] = curActive && (CW'(i) >= curOff) && (CW'(i) < curEnd);
    end

    if (!curActive) begin
      state_d = IDLE;
    end else if (curOff >= CW'(8)) begin
      state_d = DELAY;
      off_d   = curOff - CW'(8);
      rem_d   = curRem;
    end else if (!finalWord) begin
      state_d = HIGH;
      off_d   = '0;
      rem_d   = curEnd - CW'(8);
    end else if (chainFromHold || bypass) begin
      // Next reference point is the end tick inside this word; rebase to the next word.
      state_d = DELAY;
      off_d   = curEnd + chainDp - CW'(8);
      rem_d   = CW'(chainWidth);
      if (CW'(chainDelay) < CW'(MIN_GAP)) begin
        gap_d = 1'b1;
      end
    end else begin
      state_d = IDLE;
    end
    done_d = finalWord;

    if (acceptLive && !bypass) begin
      holdValid_d = 1'b1;
      holdDelay_d = cmd_delay;
      holdWidth_d = cmd_width;
    end

    if (abort) begin
      state_d     = IDLE;
      word_d      = '0;
      done_d      = 1'b0;
      holdValid_d = 1'b0;
      gap_d       = gap_q;
    end
  end

  always_ff @(posedge clk1x or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      off_q       <= '0;
      rem_q       <= '0;
      holdValid_q <= 1'b0;
      holdDelay_q <= '0;
      holdWidth_q <= '0;
      word_q      <= '0;
      done_q      <= 1'b0;
      gap_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      rem_q       <= rem_d;
      holdValid_q <= holdValid_d;
      holdDelay_q <= holdDelay_d;
      holdWidth_q <= holdWidth_d;
      word_q      <= word_d;
      done_q      <= done_d;
      gap_q       <= gap_d;
    end
  end

  assign word       = word_q;
  assign pulse_done = done_q;
  assign gap_err    = gap_q;
  assign busy       = (state_q != IDLE) || holdValid_q;

endmodule

// File: tb/tb_pulse_word_scheduler.sv
// Scoreboard bench for pulse_word_scheduler: an absolute-tick reference model
// predicts every word; a separate monitor compares DUT outputs each cycle.
module tb_pulse_word_scheduler;

  localparam int DW      = 16;
  localparam int MIN_GAP = 8;

  logic          clk1x = 1'b0;
  logic          rst;
  logic          cmdValid;
  logic          cmdReady;
  logic [DW-1:0] cmdDelay;
  logic [DW-1:0] cmdWidth;
  logic          abortIn;
  logic [7:0]    word;
  logic          busy;
  logic          pulseDone;
  logic          gapErr;

  pulse_word_scheduler #(.DW(DW), .MIN_GAP(MIN_GAP)) dut (
    .clk1x     (clk1x),
    .rst       (rst),
    .cmd_valid (cmdValid),
    .cmd_ready (cmdReady),
    .cmd_delay (cmdDelay),
    .cmd_width (cmdWidth),
    .abort     (abortIn),
    .word      (word),
    .busy      (busy),
    .pulse_done(pulseDone),
    .gap_err   (gapErr)
  );

  always #5 clk1x = ~clk1x;

  typedef struct {
    logic       rdy;
    logic [7:0] word;
    logic       done;
    logic       busy;
    logic       gap;
    longint     edgeNum;
  } exp_t;

  exp_t expQ[$];
  int   testsRun    = 0;
  int   testsFailed = 0;

  // Reference model: pulses live on an absolute tick timeline; the word
  // registered at edge e covers ticks 8e..8e+7.
  bit     mActive;
  longint mStart, mEnd;
  bit     mHoldValid;
  int     mHoldD, mHoldW;
  bit     mGap;
  longint mEdge;

  task automatic checkOutput(input string name, input longint edgeNum,
                             input logic [7:0] actual, input logic [7:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, edgeNum, actual, expected);
    end
  endtask

  task automatic modelReset();
    mActive    = 0;
    mStart     = 0;
    mEnd       = 0;
    mHoldValid = 0;
    mHoldD     = 0;
    mHoldW     = 0;
    mGap       = 0;
    mEdge      = 0;
  endtask

  task automatic modelChain(input int d, input int w);
    int dp;
    dp = (d < MIN_GAP) ? MIN_GAP : d;
    if (d < MIN_GAP) mGap = 1;
    mStart  = mEnd + dp;
    mEnd    = mStart + w;
    mActive = 1;
  endtask

  task automatic applyStimulus(input bit v, input int d, input int w, input bit ab);
    exp_t   e;
    bit     wasActive, consumedIdle, consumedChain, done, ready, accept, bypassed;
    longint base;
    @(negedge clk1x);
    cmdValid = v;
    cmdDelay = d[DW-1:0];
    cmdWidth = w[DW-1:0];
    abortIn  = ab;
    #2;
    base          = mEdge * 8;
    wasActive     = mActive;
    consumedIdle  = 0;
    consumedChain = 0;
    bypassed      = 0;
    e.word        = 8'h00;
    e.done        = 0;
    if (ab) begin
      e.rdy      = 0;
      mActive    = 0;
      mHoldValid = 0;
    end else begin
      if (!mActive && mHoldValid) begin
        mStart       = base + mHoldD;
        mEnd         = mStart + mHoldW;
        mActive      = 1;
        consumedIdle = 1;
      end
      for (int i = 0; i < 8; i++) begin
        e.word[i] = mActive && (base + i >= mStart) && (base + i < mEnd);
      end
      done          = mActive && (mEnd - 1 >= base) && (mEnd - 1 < base + 8);
      consumedChain = wasActive && done && mHoldValid;
      ready         = !mHoldValid || consumedIdle || consumedChain;
      accept        = v && ready;
      e.rdy         = ready;
      e.done        = done;
      if (done) begin
        mActive = 0;
        if (consumedChain) begin
          modelChain(mHoldD, mHoldW);
        end else if (accept && w != 0) begin
          modelChain(d, w);
          bypassed = 1;
        end
      end
      if (consumedIdle || consumedChain) mHoldValid = 0;
      if (accept && w != 0 && !bypassed) begin
        mHoldValid = 1;
        mHoldD     = d;
        mHoldW     = w;
      end
    end
    e.busy    = mActive || mHoldValid;
    e.gap     = mGap;
    e.edgeNum = mEdge;
    expQ.push_back(e);
    mEdge++;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0);
  endtask

  task automatic applyReset();
    @(negedge clk1x);
    rst      = 1'b1;
    cmdValid = 1'b1;
    abortIn  = 1'b0;
    #1;
    checkOutput("async_reset_word", -1, word, 8'h00);
    repeat (2) @(negedge clk1x);
    checkOutput("reset_word", -1, word, 8'h00);
    checkOutput("reset_busy", -1, {7'b0, busy}, 8'h00);
    checkOutput("reset_pulse_done", -1, {7'b0, pulseDone}, 8'h00);
    checkOutput("reset_gap_err", -1, {7'b0, gapErr}, 8'h00);
    rst      = 1'b0;
    cmdValid = 1'b0;
    modelReset();
  endtask

  // Monitor: samples cmd_ready just before each checked edge and the
  // registered outputs just after it, then compares against the queue head.
  initial begin
    exp_t e;
    logic rdySample;
    forever begin
      @(negedge clk1x);
      #3;
      if (expQ.size() == 0) continue;
      rdySample = cmdReady;
      @(posedge clk1x);
      #1;
      e = expQ.pop_front();
      checkOutput("cmd_ready", e.edgeNum, {7'b0, rdySample}, {7'b0, e.rdy});
      checkOutput("word", e.edgeNum, word, e.word);
      checkOutput("pulse_done", e.edgeNum, {7'b0, pulseDone}, {7'b0, e.done});
      checkOutput("busy", e.edgeNum, {7'b0, busy}, {7'b0, e.busy});
      checkOutput("gap_err", e.edgeNum, {7'b0, gapErr}, {7'b0, e.gap});
    end
  end

  initial begin
    rst      = 1'b1;
    cmdValid = 1'b0;
    cmdDelay = '0;
    cmdWidth = '0;
    abortIn  = 1'b0;
    modelReset();

    applyReset();
    applyStimulus(1, 0, 3, 0);
    idleCycles(3);
    applyStimulus(1, 5, 6, 0);
    idleCycles(4);
    applyStimulus(1, 0, 20, 0);
    idleCycles(4);
    applyStimulus(1, 19, 1, 0);
    idleCycles(4);

    applyReset();
    applyStimulus(1, 0, 4, 0);
    applyStimulus(1, 2, 2, 0);
    idleCycles(4);

    applyReset();
    applyStimulus(1, 0, 4, 0);
    applyStimulus(1, 9, 2, 0);
    idleCycles(4);

    applyReset();
    applyStimulus(1, 0, 40, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 3, 5, 0);
    applyStimulus(1, 1, 1, 1);
    idleCycles(8);
    applyStimulus(1, 2, 0, 0);
    idleCycles(3);

    applyStimulus(1, 0, 40, 0);
    idleCycles(2);
    applyReset();

    for (int i = 0; i < 400; i++) begin
      int d;
      d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 200)) : int'($urandom_range(0, 20));
      applyStimulus($urandom_range(0, 1) == 1, d, int'($urandom_range(0, 24)),
                    $urandom_range(0, 40) == 0);
    end
    idleCycles(40);

    applyReset();
    applyStimulus(1, 65535, 65535, 0);
    idleCycles(16390);

    @(negedge clk1x);
    @(negedge clk1x);
    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
